// File: rtl/mod_sysbus_responder.sv
// mod_sysbus_responder: memory-backed system-bus target.
// It accepts a one-beat line address followed (for writes) by eight data
// beats, or answers a read with eight data beats after a fixed latency.
// The backing store holds MEM_LINES lines of 64 bytes, organised as eight
// DATA_WIDTH-bit beats per line, and keeps its contents across reset.
module mod_sysbus_responder #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13,
  parameter int MEM_LINES  = 256,
  parameter int RD_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reqcyc,
  input  logic [DATA_WIDTH-1:0] req,
  input  logic [TAG_WIDTH-1:0]  reqtag,
  output logic                  reqack,
  output logic                  respcyc,
  output logic [DATA_WIDTH-1:0] resp,
  output logic [TAG_WIDTH-1:0]  resptag,
  input  logic                  respack
);

  // MEM_LINES is a power of two of at least 2, so the line index is exact.
  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int DEPTH = MEM_LINES * 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2,
    WR_DATA = 2'd3
  } state_e;

  state_e                 state_q,   state_d;
  logic [2:0]             beat_q,    beat_d;
  logic [LAT_W-1:0]       lat_q,     lat_d;
  logic [IDX_W-1:0]       line_q,    line_d;
  logic [TAG_WIDTH-1:0]   tag_q,     tag_d;
  logic                   respcyc_q, respcyc_d;
  logic [DATA_WIDTH-1:0]  resp_q,    resp_d;
  logic [TAG_WIDTH-1:0]   resptag_q, resptag_d;

  logic                   reqack_c;
  logic                   mem_we;
  logic [2:0]             rd_sel;
  logic [DATA_WIDTH-1:0]  mem_rdata;

  // Backing store, one entry per beat, addressed as {line, beat}.
  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  // Beat to pre-fetch: beat 0 while waiting, otherwise the beat after the
  // one currently on resp, so the response register can advance with no gap.
  assign rd_sel    = (state_q == RD_RESP) ? beat_q + 3'd1 : 3'd0;
  assign mem_rdata = mem[{line_q, rd_sel}];

  // Next-state and next-output computation for the transaction FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; otherwise synthesis would infer a latch.
    state_d   = state_q;
    beat_d    = beat_q;
    lat_d     = lat_q;
    line_d    = line_q;
    tag_d     = tag_q;
    respcyc_d = respcyc_q;
    resp_d    = resp_q;
    resptag_d = resptag_q;
    reqack_c  = 1'b0;
    mem_we    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (reqcyc) begin
          reqack_c = 1'b1;
          line_d   = req[6 +: IDX_W];
          tag_d    = reqtag;
          beat_d   = 3'd0;
          lat_d    = '0;
          state_d  = reqtag[0] ? RD_WAIT : WR_DATA;
        end
      end

      RD_WAIT: begin
        if (lat_q == LAT_W'(RD_LATENCY - 1)) begin
          state_d   = RD_RESP;
          beat_d    = 3'd0;
          respcyc_d = 1'b1;
          resp_d    = mem_rdata;
          resptag_d = tag_q;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      RD_RESP: begin
        if (respack) begin
          if (beat_q == 3'd7) begin
            state_d   = IDLE;
            beat_d    = 3'd0;
            respcyc_d = 1'b0;
            resp_d    = '0;
            resptag_d = '0;
          end else begin
            beat_d = beat_q + 3'd1;
            resp_d = mem_rdata;
          end
        end
      end

      WR_DATA: begin
        if (reqcyc) begin
          reqack_c = 1'b1;
          mem_we   = 1'b1;
          // The 7 -> 0 wrap of the beat counter coincides with the exit.
          beat_d   = beat_q + 3'd1;
          if (beat_q == 3'd7) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // reqack is decoded in the same cycle the beat is consumed so write beats
  // can stream back to back; it is forced low while reset is held.
  assign reqack = reqack_c & reset;

  // State, counters and registered response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      beat_q    <= 3'd0;
      lat_q     <= '0;
      line_q    <= '0;
      tag_q     <= '0;
      respcyc_q <= 1'b0;
      resp_q    <= '0;
      resptag_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q   <= state_d;
      beat_q    <= beat_d;
      lat_q     <= lat_d;
      line_q    <= line_d;
      tag_q     <= tag_d;
      respcyc_q <= respcyc_d;
      resp_q    <= resp_d;
      resptag_q <= resptag_d;
    end
  end

  // Write port of the backing store.
  // NOTE: the memory has no reset: its contents must survive reset, and a
  // reset on an array this size would also prevent RAM inference. Writes
  // cannot occur during reset because the FSM is held in IDLE.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[{line_q, beat_q}] <= req;
    end
  end

  assign respcyc = respcyc_q;
  assign resp    = resp_q;
  assign resptag = resptag_q;

  // A request beat is never consumed while a response beat is offered.
  assert property (@(posedge clk) disable iff (!reset) !(reqack && respcyc));

  // A stalled response beat keeps its data until it is acknowledged.
  assert property (@(posedge clk) disable iff (!reset)
                   (respcyc && !respack) |=> (respcyc && $stable(resp)));

endmodule

// File: tb/tb_mod_sysbus_responder.sv
// Self-checking bench for mod_sysbus_responder: a transaction-level model
// (per-line beat array plus a queue of expected response beats) drives a
// single compare process that checks the outputs on every falling edge.
module tb_mod_sysbus_responder;

  localparam int DW  = 64;
  localparam int TW  = 13;
  localparam int ML  = 256;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          reqcyc = 1'b0;
  logic [DW-1:0] req = '0;
  logic [TW-1:0] reqtag = '0;
  logic          respack = 1'b0;
  logic          reqack;
  logic          respcyc;
  logic [DW-1:0] resp;
  logic [TW-1:0] resptag;

  mod_sysbus_responder #(
    .DATA_WIDTH(DW), .TAG_WIDTH(TW), .MEM_LINES(ML), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset), .reqcyc(reqcyc), .req(req), .reqtag(reqtag),
    .reqack(reqack), .respcyc(respcyc), .resp(resp), .resptag(resptag),
    .respack(respack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } beat_t;

  logic [DW-1:0] model_mem [ML][8];
  bit            written [ML];
  beat_t         exp_q[$];
  logic [DW-1:0] got_q[$];
  logic [TW-1:0] last_tag;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  bit rd_busy = 0;
  bit first_pending = 0;
  int acc_cyc = 0;
  int done_cyc = 0;
  bit rand_ack = 0;
  bit bp_test = 0;
  int bp_cnt = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int line_of(input logic [DW-1:0] a);
    return int'((a >> 6) % ML);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Initiator side of the response channel: always-ready, random, or a
  // forced three-cycle stall on beat 2.
  always @(posedge clk) begin
    #1;
    if (bp_test && got_q.size() == 2 && bp_cnt < 3) begin
      respack = 1'b0;
      bp_cnt++;
    end else if (rand_ack) begin
      respack = ($urandom_range(0, 2) != 0);
    end else begin
      respack = 1'b1;
    end
  end

  // Compare process: outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("rst_reqack", DW'(reqack), 0);
      check("rst_respcyc", DW'(respcyc), 0);
      check("rst_resp", resp, 0);
      check("rst_resptag", DW'(resptag), 0);
    end else begin
      if (!reqcyc || rd_busy) check("reqack_quiet", DW'(reqack), 0);
      if (exp_q.size() == 0) begin
        check("respcyc_idle", DW'(respcyc), 0);
      end else if (respcyc) begin
        if (first_pending) begin
          check("first_beat_latency", DW'(cyc), DW'(acc_cyc + LAT + 1));
          first_pending = 0;
        end
        check("resp_data", resp, exp_q[0].data);
        check("resptag", DW'(resptag), DW'(exp_q[0].tag));
        if (respack) begin
          got_q.push_back(resp);
          last_tag = resptag;
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            rd_busy  = 0;
            done_cyc = cyc;
          end
        end
      end else if (first_pending) begin
        if (cyc >= acc_cyc + LAT + 1) begin
          check("first_beat_latency", DW'(cyc), DW'(acc_cyc + LAT + 1));
          first_pending = 0;
        end
      end else begin
        check("respcyc_held", DW'(respcyc), 1);
      end
    end
  end

  // Present one request beat and wait (bounded) for its reqack.
  task automatic send_beat(input logic [DW-1:0] d, input logic [TW-1:0] t,
                           input int max_wait, output int ack_cyc);
    int waited = 0;
    reqcyc = 1'b1;
    req    = d;
    reqtag = t;
    @(negedge clk);
    while (!reqack && waited < max_wait) begin
      waited++;
      @(negedge clk);
    end
    check("reqack_beat", DW'(reqack), 1);
    ack_cyc = reqack ? cyc : -1;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset  = 1'b0;
    reqcyc = 1'b0;
    exp_q.delete();
    rd_busy = 0;
    first_pending = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic do_write(input logic [DW-1:0] addr, input logic [DW-1:0] d[8],
                          input int gap_max, input int abort_after);
    int a;
    int first_ack = 0;
    int last_ack = 0;
    int ln = line_of(addr);
    logic [TW-1:0] t;
    t = TW'($urandom);
    t[0] = 1'b0;
    send_beat(addr, t, 0, a);
    for (int k = 0; k < 8; k++) begin
      int g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      if (g > 0) begin
        reqcyc = 1'b0;
        repeat (g) @(posedge clk);
        #1;
      end
      send_beat(d[k], t, 0, a);
      if (a >= 0) model_mem[ln][k] = d[k];
      if (k == 0) first_ack = a;
      last_ack = a;
      if (k == abort_after) begin
        apply_reset();
        return;
      end
    end
    reqcyc = 1'b0;
    written[ln] = 1;
    if (gap_max == 0) check("wr_burst_span", DW'(last_ack - first_ack), 7);
  endtask

  task automatic wait_read_done();
    for (int i = 0; i < 200 && rd_busy; i++) @(posedge clk);
    #1;
    check("read_done", DW'(rd_busy), 0);
    if (rd_busy) begin
      exp_q.delete();
      rd_busy = 0;
      first_pending = 0;
    end
  endtask

  task automatic do_read(input logic [DW-1:0] addr, input logic [TW-1:0] tag,
                         input int max_wait, input bit wait_done);
    int a;
    int ln = line_of(addr);
    send_beat(addr, tag, max_wait, a);
    reqcyc = 1'b0;
    if (a < 0) return;
    if (max_wait > 0) check("busy_accept_cycle", DW'(a), DW'(done_cyc + 1));
    acc_cyc = a;
    got_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back('{data: model_mem[ln][k], tag: tag});
    first_pending = 1;
    rd_busy = 1;
    if (wait_done) wait_read_done();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] pat_a[8], pat_b[8], pat_old[8], pat_new[8], rnd[8];

  initial begin
    for (int k = 0; k < 8; k++) begin
      pat_a[k]   = {8{8'(8'h11 * (k + 1))}};
      pat_b[k]   = 64'hA0A0_0000_0000_0000 + 64'(k);
      pat_old[k] = 64'h0123_4567_0000_0000 | 64'(k);
      pat_new[k] = 64'hFEDC_BA98_0000_0000 | 64'(k);
    end

    // Reset state, then a request on the very first edge after release.
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    do_write(64'h1000, pat_a, 0, -1);

    // Write then read with tag 0x0003.
    do_read(64'h1000, 13'h0003, 0, 1);
    check("wr_rd_count", DW'(got_q.size()), 8);
    check("wr_rd_beat0", got_q[0], 64'h1111_1111_1111_1111);
    check("wr_rd_beat3", got_q[3], 64'h4444_4444_4444_4444);
    check("wr_rd_beat7", got_q[7], 64'h8888_8888_8888_8888);
    check("wr_rd_tag", DW'(last_tag), 64'h3);

    // Backpressure on beat 2.
    bp_test = 1;
    bp_cnt = 0;
    do_read(64'h1000, 13'h0005, 0, 1);
    bp_test = 0;
    check("bp_count", DW'(got_q.size()), 8);
    check("bp_stall_cycles", DW'(bp_cnt), 3);
    check("bp_beat2", got_q[2], 64'h3333_3333_3333_3333);

    // Address wrap: 0x4000 aliases line 0.
    do_write(64'h4000, pat_b, 0, -1);
    do_read(64'h0000, 13'h0007, 0, 1);
    check("wrap_beat0", got_q[0], 64'hA0A0_0000_0000_0000);
    check("wrap_beat7", got_q[7], 64'hA0A0_0000_0000_0007);

    // Busy: next request held during the read, accepted right after it.
    do_read(64'h0000, 13'h0009, 0, 0);
    do_read(64'h1000, 13'h000B, 60, 1);
    check("busy_next_beat5", got_q[5], 64'h6666_6666_6666_6666);

    // Reset after write beat 3: beats 0-3 new, 4-7 old.
    do_write(64'h2000, pat_old, 2, -1);
    do_write(64'h2000, pat_new, 0, 3);
    do_read(64'h2000, 13'h000D, 0, 1);
    check("rst_wr_beat0", got_q[0], 64'hFEDC_BA98_0000_0000);
    check("rst_wr_beat3", got_q[3], 64'hFEDC_BA98_0000_0003);
    check("rst_wr_beat4", got_q[4], 64'h0123_4567_0000_0004);
    check("rst_wr_beat7", got_q[7], 64'h0123_4567_0000_0007);

    // Reset in the middle of a read response, then the line reads intact.
    do_read(64'h2000, 13'h000F, 0, 0);
    for (int i = 0; i < 100 && got_q.size() < 3; i++) @(posedge clk);
    #1;
    apply_reset();
    repeat (4) @(posedge clk);
    #1;
    do_read(64'h2000, 13'h0011, 0, 1);
    check("post_abort_beat5", got_q[5], 64'h0123_4567_0000_0005);

    // Randomized traffic with random response backpressure and write gaps.
    rand_ack = 1;
    for (int n = 0; n < 40; n++) begin
      logic [DW-1:0] addr;
      int ln;
      addr = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0: ln = 0;
        1: ln = 1;
        2: ln = 64;
        3: ln = 128;
        default: ln = 255;
      endcase
      addr[6 +: 8] = 8'(ln);
      if (!written[ln] || $urandom_range(0, 1) == 0) begin
        for (int k = 0; k < 8; k++) rnd[k] = {$urandom, $urandom};
        do_write(addr, rnd, $urandom_range(0, 2), -1);
      end else begin
        logic [TW-1:0] t;
        t = TW'($urandom);
        t[0] = 1'b1;
        do_read(addr, t, 0, 1);
        check("rand_read_count", DW'(got_q.size()), 8);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mod_sysbus_responder.md
MOD_SYSBUS_RESPONDER -- requirements
Module: mod_sysbus_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning the width of one bus beat in bits.
REQ-002 SHALL have parameter TAG_WIDTH, default 13, meaning the request/response tag width.
REQ-003 SHALL have parameter MEM_LINES, default 256, meaning the number of 64-byte backing lines (a power of 2).
REQ-004 SHALL have parameter RD_LATENCY, default 4, meaning the cycles from read acceptance to the first response beat (minimum 1).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port reqcyc, input, 1 bit: the initiator presents a request beat.
REQ-008 SHALL have port req, input, DATA_WIDTH bits: the line byte address on the first beat, then write data beats.
REQ-009 SHALL have port reqtag, input, TAG_WIDTH bits: request tag; bit 0 = 1 means READ and 0 means WRITE.
REQ-010 SHALL have port reqack, output, 1 bit: one-cycle pulse marking the current request beat as consumed.
REQ-011 SHALL have port respcyc, output, 1 bit: a response beat is valid.
REQ-012 SHALL have port resp, output, DATA_WIDTH bits: read data beat.
REQ-013 SHALL have port resptag, output, TAG_WIDTH bits: the tag of the request being answered.
REQ-014 SHALL have port respack, input, 1 bit: the initiator consumes the current response beat.

Function
REQ-015 SHALL implement states IDLE, RD_WAIT, RD_RESP and WR_DATA.
REQ-016 In IDLE with reqcyc=1, the block SHALL:
- latch req as the address and reqtag as the tag;
- pulse reqack for exactly one cycle;
- move to RD_WAIT if reqtag[0]=1, otherwise to WR_DATA.
REQ-017 Line index SHALL be address[6 +: log2(MEM_LINES)]; address bits [5:0] and bits above the index SHALL be ignored, so out-of-range addresses wrap modulo MEM_LINES.
REQ-018 RD_WAIT SHALL count RD_LATENCY cycles after the acceptance cycle, then enter RD_RESP with the beat counter at 0.
REQ-019 In RD_RESP the block SHALL:
- drive respcyc=1, resptag set to the latched tag, and resp set to bytes 8k..8k+7 of the line for beat k, with byte 8k in resp[7:0];
- hold resp stable until respack=1;
- advance k by one on each cycle where respcyc and respack are both 1.
REQ-020 When beat 7 is acknowledged, the block SHALL drop respcyc on the next cycle and return to IDLE.
REQ-021 IDLE SHALL be able to accept a new request on the cycle after the return.
REQ-022 In WR_DATA each cycle with reqcyc=1 SHALL:
- store req into bytes 8k..8k+7 of the indexed line;
- pulse reqack;
- increment k.
REQ-023 Back-to-back write beats SHALL be accepted with no bubble, and a reqack pulse SHALL never cover two beats.
REQ-024 After write beat 7 the block SHALL return to IDLE without issuing any response beat; respcyc SHALL stay 0 for the entire write.
REQ-025 reqcyc SHALL be ignored (no reqack) in RD_WAIT and RD_RESP.
REQ-026 A read to a line SHALL return the data of the most recent completed write to that line.
REQ-027 The beat counter SHALL be 3 bits; wrap from 7 to 0 only coincides with a state exit.
REQ-028 respack=1 while respcyc=0 SHALL have no effect.

Reset
REQ-029 While reset=0, outputs SHALL be reqack=0, respcyc=0, resp=0 and resptag=0; state SHALL be IDLE, and the beat and latency counters SHALL be 0.
REQ-030 Reset asserted mid-read or mid-write SHALL abort the transaction immediately; no further beats SHALL be produced or consumed.
REQ-031 On reset, already-written memory beats SHALL be retained and memory SHALL NOT be cleared.
REQ-032 The first request SHALL be accepted on the first rising edge at which reset=1 and reqcyc=1.

Verification
REQ-033 Write then read: write line 0x1000, tag bit0=0, beats 0x11..0x88 repeated per byte; then read 0x1000 with tag 0x0003 -> 8 beats in order, resptag=0x0003, first respcyc exactly RD_LATENCY+1 cycles after the read reqack.
REQ-034 Backpressure: respack held low for 3 cycles on beat 2 -> resp stays stable and the beat count stays 8 with no beat skipped or duplicated.
REQ-035 Wrap: write address 0x4000 with MEM_LINES=256, then read address 0x0000 -> identical data.
REQ-036 Busy: reqcyc held high during RD_RESP -> reqack stays 0; the request is accepted on the cycle after the return to IDLE.
REQ-037 Reset after write beat 3, then read the same line -> beats 0-3 hold the new data, beats 4-7 hold the old data, and respcyc=0 throughout reset.
REQ-038 Continuous write beats: reqcyc=1 for 8 consecutive cycles -> 8 reqack pulses, and respcyc is never asserted.
